// File: rtl/ir_sequencer_if.sv
// ---------------------------------------------------------------------------
// ir_sequencer_if
// Bundles the two buses the instruction sequencer talks on:
//   - instruction-memory read bus: o_mem_rd / o_mem_addr out, i_mem_data /
//     i_mem_valid back (variable latency, one valid per request)
//   - device issue bus: o_issue_valid / o_device / o_port out, i_issue_ready
//     back (valid/ready handshake)
// Signal prefixes are from the sequencer's point of view.
// Modports:
//   master - the sequencer (drives o_*, samples i_*)
//   slave  - memory / device bus side (drives i_*, samples o_*)
// ---------------------------------------------------------------------------
interface ir_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  o_mem_rd;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic                  i_mem_valid;
  logic                  o_issue_valid;
  logic                  i_issue_ready;
  logic [DATA_WIDTH-1:0] o_device;
  logic [DATA_WIDTH-1:0] o_port;

  modport master (
    output o_mem_rd, o_mem_addr, o_issue_valid, o_device, o_port,
    input  i_mem_data, i_mem_valid, i_issue_ready
  );

  modport slave (
    input  o_mem_rd, o_mem_addr, o_issue_valid, o_device, o_port,
    output i_mem_data, i_mem_valid, i_issue_ready
  );
endinterface

// File: rtl/ir_sequencer.sv
// ---------------------------------------------------------------------------
// ir_sequencer
// Walks a PC through instruction memory, fetching two-word instructions
// (device ID word, then port word) over a variable-latency read bus, and
// presents each device/port pair on a valid/ready issue bus. Stops on an END
// instruction (device ID 0, reported with a one-cycle o_done) or on i_halt.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   i_start        start pulse, only honoured in IDLE
//   i_start_addr   first instruction address, sampled with i_start
//   i_halt         abort request, honoured in every non-IDLE state
//   bus            ir_sequencer_if.master: memory read bus + issue bus
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse after an END instruction is fetched
//   o_icount       instructions issued since the last start
//
// o_mem_addr always shows the PC; it is only meaningful to memory while
// o_mem_rd is high. All strobes (o_mem_rd, o_issue_valid, o_busy, o_done)
// are decoded from state alone.
// ---------------------------------------------------------------------------
module ir_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic                  i_halt,
  ir_sequencer_if.master        bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_icount
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ_DEV   = 3'd1,
    S_WAIT_DEV  = 3'd2,
    S_REQ_PORT  = 3'd3,
    S_WAIT_PORT = 3'd4,
    S_ISSUE     = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                state_q,  state_d;
  logic [ADDR_WIDTH-1:0] pc_q,     pc_d;
  logic [DATA_WIDTH-1:0] device_q, device_d;
  logic [DATA_WIDTH-1:0] port_q,   port_d;
  logic [CNT_WIDTH-1:0]  icount_q, icount_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      device_q <= '0;
      port_q   <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      device_q <= device_d;
      port_q   <= port_d;
      icount_q <= icount_d;
    end
  end

  // Next-state and datapath updates. A halt always wins the state choice;
  // in WAIT states it also suppresses the capture so PC/device/port hold.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    device_d = device_q;
    port_d   = port_q;
    icount_d = icount_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          pc_d     = i_start_addr;
          icount_d = '0;
          state_d  = S_REQ_DEV;
        end
      end

      // The read strobe for this cycle is already out; a halt only stops
      // us from waiting for its response.
      S_REQ_DEV:  state_d = i_halt ? S_IDLE : S_WAIT_DEV;
      S_REQ_PORT: state_d = i_halt ? S_IDLE : S_WAIT_PORT;

      S_WAIT_DEV: begin
        if (i_halt) begin
          state_d = S_IDLE;
        end else if (bus.i_mem_valid) begin
          device_d = bus.i_mem_data;
          pc_d     = pc_q + ADDR_WIDTH'(1);
          state_d  = (bus.i_mem_data == '0) ? S_DONE : S_REQ_PORT;
        end
      end

      S_WAIT_PORT: begin
        if (i_halt) begin
          state_d = S_IDLE;
        end else if (bus.i_mem_valid) begin
          port_d  = bus.i_mem_data;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = S_ISSUE;
        end
      end

      // A handshake in the same cycle as a halt still counts.
      S_ISSUE: begin
        if (bus.i_issue_ready) begin
          icount_d = icount_q + CNT_WIDTH'(1);
        end
        if (i_halt) begin
          state_d = S_IDLE;
        end else if (bus.i_issue_ready) begin
          state_d = S_REQ_DEV;
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_mem_rd      = (state_q == S_REQ_DEV) || (state_q == S_REQ_PORT);
  assign bus.o_mem_addr    = pc_q;
  assign bus.o_issue_valid = (state_q == S_ISSUE);
  assign bus.o_device      = device_q;
  assign bus.o_port        = port_q;
  assign o_busy            = (state_q != S_IDLE);
  assign o_done            = (state_q == S_DONE);
  assign o_icount          = icount_q;

endmodule

// File: tb/tb_ir_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ir_sequencer
// Directed bench for ir_sequencer: a behavioural instruction memory with
// programmable latency, an issue/read/done monitor, and directed scenarios
// with hand-computed expected values.
// Stimulus changes 1 time unit after the falling edge; the monitor samples
// 2 time units after the falling edge; rising edges are at +5.
// ---------------------------------------------------------------------------
module tb_ir_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  start_addr_i = 8'h00;
  logic        halt_i = 1'b0;
  logic        ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic [15:0] icount_o;

  always #5 clk = ~clk;

  ir_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ir_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start_i),
    .i_start_addr (start_addr_i),
    .i_halt       (halt_i),
    .bus          (bus),
    .o_busy       (busy_o),
    .o_done       (done_o),
    .o_icount     (icount_o)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [256];
  int         lat = 1;
  int         pend_cnt = 0;
  logic [7:0] pend_addr = 8'h00;
  logic       model_valid = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic       stray_valid = 1'b0;

  // One response per request, presented for one cycle, lat cycles after the
  // cycle carrying the read strobe. Not cleared by rst on purpose.
  always @(negedge clk) begin
    model_valid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
      if (pend_cnt == 0) begin
        model_valid = 1'b1;
        model_data  = mem[pend_addr];
      end
    end
    if (bus.o_mem_rd === 1'b1) begin
      pend_addr = bus.o_mem_addr;
      pend_cnt  = lat;
    end
  end

  assign bus.i_mem_valid   = model_valid | stray_valid;
  assign bus.i_mem_data    = stray_valid ? 8'h00 : model_data;
  assign bus.i_issue_ready = ready_i;

  // ---------------- monitor ----------------
  logic [7:0] hs_dev  [8];
  logic [7:0] hs_port [8];
  int         hs_cyc  [8];
  int         hs_n = 0;
  int         rd_cnt = 0;
  int         done_cnt = 0;
  int         cyc = 0;

  always begin
    @(negedge clk);
    #2;
    if (bus.o_issue_valid === 1'b1 && ready_i) begin
      if (hs_n < 8) begin
        hs_dev[hs_n]  = bus.o_device;
        hs_port[hs_n] = bus.o_port;
        hs_cyc[hs_n]  = cyc;
      end
      hs_n = hs_n + 1;
    end
    if (bus.o_mem_rd === 1'b1) rd_cnt = rd_cnt + 1;
    if (done_o === 1'b1) done_cnt = done_cnt + 1;
    cyc = cyc + 1;
  end

  // ---------------- helpers ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_n     = 0;
    done_cnt = 0;
  endtask

  task automatic run_start(input logic [7:0] addr);
    step();
    start_i      = 1'b1;
    start_addr_i = addr;
    step();
    start_i      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      step();
      n = n + 1;
    end
    check_value(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_issue(input string tag, input int budget);
    int n = 0;
    while (!bus.o_issue_valid && n < budget) begin
      step();
      n = n + 1;
    end
    check_value(tag, 32'(bus.o_issue_valid), 32'd1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int rd_snap;
    int cyc_first;
    int nrd;
    int n;

    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    // basic program
    mem[8'h10] = 8'h03; mem[8'h11] = 8'h21; mem[8'h12] = 8'h05;
    mem[8'h13] = 8'h42; mem[8'h14] = 8'h00;
    // back-pressure program
    mem[8'h20] = 8'h0A; mem[8'h21] = 8'h0B; mem[8'h22] = 8'h00;
    // wrapping program
    mem[8'hFF] = 8'h07; mem[8'h00] = 8'h11; mem[8'h01] = 8'h00;
    // halt program
    mem[8'h30] = 8'h0C; mem[8'h31] = 8'h0D; mem[8'h32] = 8'h00;
    // restart program
    mem[8'h40] = 8'h01; mem[8'h41] = 8'h02; mem[8'h42] = 8'h00;
    // reset-abort program
    mem[8'h50] = 8'h09; mem[8'h51] = 8'h0A; mem[8'h52] = 8'h00;

    // ---- reset state ----
    step();
    check_value("rst_busy",   32'(busy_o), 32'd0);
    check_value("rst_rd",     32'(bus.o_mem_rd), 32'd0);
    check_value("rst_addr",   32'(bus.o_mem_addr), 32'd0);
    check_value("rst_valid",  32'(bus.o_issue_valid), 32'd0);
    check_value("rst_devport", {16'd0, bus.o_device, bus.o_port}, 32'd0);
    check_value("rst_done",   32'(done_o), 32'd0);
    check_value("rst_icount", 32'(icount_o), 32'd0);
    rst = 1'b0;

    // ---- basic program, L=1, ready high, start while busy ignored ----
    lat = 1; ready_i = 1'b1;
    clear_log();
    run_start(8'h10);
    check_value("basic_first_rd",   32'(bus.o_mem_rd), 32'd1);
    check_value("basic_first_addr", 32'(bus.o_mem_addr), 32'h10);
    repeat (3) step();
    start_i = 1'b1; start_addr_i = 8'h80;
    step();
    start_i = 1'b0;
    wait_idle("basic_idle", 100);
    check_value("basic_hs_n",    32'(hs_n), 32'd2);
    check_value("basic_pair0",   {16'd0, hs_dev[0], hs_port[0]}, 32'h0321);
    check_value("basic_pair1",   {16'd0, hs_dev[1], hs_port[1]}, 32'h0542);
    check_value("basic_interval", 32'(hs_cyc[1] - hs_cyc[0]), 32'd5);
    check_value("basic_done",    32'(done_cnt), 32'd1);
    check_value("basic_icount",  32'(icount_o), 32'd2);
    check_value("basic_pc",      32'(bus.o_mem_addr), 32'h15);

    // ---- back-pressure: ready low for 7 ISSUE cycles ----
    clear_log();
    ready_i = 1'b0;
    run_start(8'h20);
    wait_issue("bp_valid", 40);
    rd_snap   = rd_cnt;
    cyc_first = cyc;
    for (int k = 1; k < 7; k++) begin
      step();
      check_value($sformatf("bp_stall%0d", k),
                  {15'd0, bus.o_issue_valid, bus.o_device, bus.o_port},
                  32'h10A0B);
    end
    step();
    ready_i = 1'b1;
    step();
    check_value("bp_hs_n",   32'(hs_n), 32'd1);
    check_value("bp_hs_cyc", 32'(hs_cyc[0] - cyc_first), 32'd7);
    check_value("bp_no_rd",  32'(rd_cnt - rd_snap), 32'd0);
    wait_idle("bp_idle", 60);
    check_value("bp_icount", 32'(icount_o), 32'd1);

    // ---- PC wrap with L=3 and stray valids in REQ/ISSUE ----
    clear_log();
    lat = 3;
    run_start(8'hFF);
    n = 0;
    while (busy_o && n < 80) begin
      step();
      stray_valid = bus.o_mem_rd | bus.o_issue_valid;
      n = n + 1;
    end
    stray_valid = 1'b0;
    check_value("wrap_idle",   32'(busy_o), 32'd0);
    check_value("wrap_hs_n",   32'(hs_n), 32'd1);
    check_value("wrap_pair",   {16'd0, hs_dev[0], hs_port[0]}, 32'h0711);
    check_value("wrap_done",   32'(done_cnt), 32'd1);
    check_value("wrap_pc",     32'(bus.o_mem_addr), 32'h02);
    check_value("wrap_icount", 32'(icount_o), 32'd1);

    // ---- halt in WAIT_PORT together with the port response ----
    clear_log();
    lat = 2;
    run_start(8'h30);
    nrd = 0;
    n   = 0;
    while (n < 40) begin
      if (bus.o_mem_rd) nrd = nrd + 1;
      if (nrd == 2 && !bus.o_mem_rd && bus.i_mem_valid) break;
      step();
      n = n + 1;
    end
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    check_value("hwp_busy",    32'(busy_o), 32'd0);
    check_value("hwp_devport", {16'd0, bus.o_device, bus.o_port}, 32'h0C11);
    check_value("hwp_pc",      32'(bus.o_mem_addr), 32'h31);
    repeat (5) step();
    check_value("hwp_no_issue", 32'(hs_n), 32'd0);
    check_value("hwp_no_done",  32'(done_cnt), 32'd0);

    // ---- halt in ISSUE together with ready ----
    clear_log();
    lat = 1; ready_i = 1'b1;
    run_start(8'h30);
    wait_issue("hi_valid", 40);
    halt_i = 1'b1;
    rd_snap = rd_cnt;
    step();
    halt_i = 1'b0;
    check_value("hi_busy",   32'(busy_o), 32'd0);
    check_value("hi_icount", 32'(icount_o), 32'd1);
    check_value("hi_pc",     32'(bus.o_mem_addr), 32'h32);
    repeat (4) step();
    check_value("hi_hs_n",   32'(hs_n), 32'd1);
    check_value("hi_no_rd",  32'(rd_cnt - rd_snap), 32'd0);
    check_value("hi_no_done", 32'(done_cnt), 32'd0);

    // ---- restart at 0x40 clears the counter ----
    clear_log();
    run_start(8'h40);
    check_value("rs_icount0", 32'(icount_o), 32'd0);
    wait_idle("rs_idle", 60);
    check_value("rs_pair",   {16'd0, hs_dev[0], hs_port[0]}, 32'h0102);
    check_value("rs_icount", 32'(icount_o), 32'd1);
    check_value("rs_done",   32'(done_cnt), 32'd1);

    // ---- async reset in WAIT_DEV, late response ignored ----
    clear_log();
    lat = 4;
    run_start(8'h50);
    step();
    #1 rst = 1'b1;
    #1;
    check_value("ar_busy",   32'(busy_o), 32'd0);
    check_value("ar_outs",   {bus.o_device, bus.o_port, bus.o_mem_addr, 8'd0}, 32'd0);
    check_value("ar_icount", 32'(icount_o), 32'd0);
    #1 rst = 1'b0;
    rd_snap = rd_cnt;
    repeat (8) step();
    check_value("ar_stay_idle", 32'(busy_o), 32'd0);
    check_value("ar_dev",       32'(bus.o_device), 32'd0);
    check_value("ar_no_rd",     32'(rd_cnt - rd_snap), 32'd0);
    check_value("ar_no_issue",  32'(hs_n + done_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ir_sequencer.md
# ir_sequencer

Instruction sequencer in front of the fetch datapath. Walks a program counter through instruction memory, reading each two-word instruction (device ID word, then port word) over a variable-latency read interface. It presents each decoded device/port pair to the device bus with a valid/ready handshake, and stops on an END instruction (device ID 0) or on an external halt. It replaces free-running word alternation with an explicit, stallable sequence.

## Interface
- DATA_WIDTH, 8: width of instruction words, device ID and port
- ADDR_WIDTH, 8: instruction memory address width / PC width
- CNT_WIDTH, 16: width of issued-instruction counter
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_start  input  1  start pulse; sampled only in IDLE
- i_start_addr  input  ADDR_WIDTH  first instruction address, sampled with i_start
- i_halt  input  1  abort request
- o_mem_rd  output  1  one-cycle read request
- o_mem_addr  output  ADDR_WIDTH  read address (= PC)
- i_mem_data  input  DATA_WIDTH  read data
- i_mem_valid  input  1  read data valid, one cycle per request, ≥1 cycle after o_mem_rd
- o_issue_valid  output  1  device/port pair valid
- i_issue_ready  input  1  device bus accepts pair
- o_device  output  DATA_WIDTH  device ID of current instruction
- o_port  output  DATA_WIDTH  port of current instruction
- o_busy  output  1  high in every state except IDLE
- o_done  output  1  one-cycle pulse on END instruction
- o_icount  output  CNT_WIDTH  instructions issued since last start

## Operation
- States: IDLE, REQ_DEV, WAIT_DEV, REQ_PORT, WAIT_PORT, ISSUE, DONE.
- IDLE: on i_start, PC <= i_start_addr, o_icount <= 0, go REQ_DEV. Otherwise hold.
- REQ_DEV / REQ_PORT: o_mem_rd=1, o_mem_addr=PC for exactly this cycle; go to matching WAIT state.
- WAIT_DEV: on i_mem_valid, device reg <= i_mem_data and PC <= PC+1.
  - Data == 0: go DONE.
  - Otherwise: go REQ_PORT.
- WAIT_PORT: on i_mem_valid, port reg <= i_mem_data, PC <= PC+1, go ISSUE.
- ISSUE: o_issue_valid=1.
  - o_device/o_port must stay stable until i_issue_ready.
  - On valid&ready: o_icount += 1, go REQ_DEV.
- DONE: o_done=1 for one cycle, go IDLE. The END word is never issued.
- PC arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones to 0 is legal and silent.
- o_icount wraps modulo 2^CNT_WIDTH.
- i_mem_valid outside WAIT_DEV/WAIT_PORT is ignored, including late responses after a halt.
- i_start while o_busy is ignored.
- i_halt, sampled in any non-IDLE state:
  - Next state is IDLE; no o_done.
  - PC, o_device, o_port and o_icount hold their last values.
  - In ISSUE with i_issue_ready high in the same cycle, the handshake completes (o_icount increments) before going IDLE.
  - In WAIT states, a same-cycle i_mem_valid is discarded.
  - In REQ states, the read already presented this cycle is not retracted.
- o_mem_rd, o_issue_valid, o_busy and o_done are pure functions of state (Moore).

## Timing
- Reset values: state IDLE, PC 0, and all of o_mem_rd, o_mem_addr, o_issue_valid, o_device, o_port, o_busy, o_done and o_icount are 0.
- Memory latency L ≥ 1 cycle. Cycle count from o_mem_rd to capture is L+1, since capture occurs on the edge where i_mem_valid is high.
- Per-instruction minimum, with L=1 and ready always high: 5 cycles (REQ_DEV, WAIT_DEV, REQ_PORT, WAIT_PORT, ISSUE). Sustained rate is 1 instruction per 5 cycles.
- Start to first o_mem_rd: 1 cycle (i_start edge → REQ_DEV next cycle).
- END detection to o_done: 1 cycle after capture. o_busy falls in the cycle after o_done.
- o_device updates only in WAIT_DEV on capture; o_port only in WAIT_PORT on capture. Both are stable throughout ISSUE.
- Asynchronous reset mid-operation forces IDLE and all reset values immediately. Any outstanding memory response is later ignored.

## Test plan
- Basic program: memory at 0x10 = {0x03,0x21,0x05,0x42,0x00}, start_addr 0x10, L=1, ready=1.
  - Issues (0x03,0x21) then (0x05,0x42).
  - o_done once; o_icount=2; final PC=0x15.
  - 5 cycles between issue handshakes.
- Back-pressure: hold i_issue_ready low 7 cycles in ISSUE.
  - o_issue_valid stays high with o_device/o_port unchanged.
  - Handshake on cycle 8; no extra memory reads during the stall.
- Variable latency / wrap: start_addr 0xFF, L=3, program {0x07,0x11,0x00} spanning 0xFF→0x00→0x01.
  - Correct pair issued, done asserted, PC=0x02.
  - Stray i_mem_valid injected in REQ/ISSUE states has no effect.
- Halt: i_halt in WAIT_PORT with simultaneous i_mem_valid.
  - Returns IDLE, no issue, no o_done, o_port unchanged.
  - Repeat with halt in ISSUE together with ready: o_icount increments, then IDLE.
- Start ignored / restart: pulse i_start while busy → no effect. After done, restart at 0x40 → o_icount clears to 0.
- Async reset: assert rst mid-WAIT_DEV between clock edges.
  - All outputs 0 immediately.
  - Memory response arriving after release is ignored; o_busy stays 0.
